// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared state encoding and constants for the PC / fetch sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_WAIT = 2'd2;
  localparam fetch_state_t ST_HOLD = 2'd3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : 32-bit program-counter register with load enable and sync reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_data,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) pc_d = load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module : pc_fetch_unit
// Brief  : PC register plus single-outstanding instruction-fetch sequencer.
//          Optional macro MISALIGN_TRAP_EN turns a misaligned PC into a NOP
//          presented with fd_misalign instead of a memory request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        fd_misalign
);

  fetch_state_t state_d, state_q;
  logic         drop_d, drop_q;
  logic [31:0]  instr_d, instr_q;
  logic         pc_load;
  logic [31:0]  pc;
  logic         trap;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load_en   (pc_load),
    .load_data (next_pc),
    .pc        (pc)
  );

`ifdef MISALIGN_TRAP_EN
  logic misalign_d, misalign_q;
  assign trap        = (pc[1:0] != 2'b00);
  assign fd_misalign = misalign_q && (state_q == ST_HOLD);
`else
  assign trap        = 1'b0;
  assign fd_misalign = 1'b0;
`endif

  assign pc_plus4       = pc + 32'(INSTR_BYTES);
  assign imem_addr      = word_addr(pc);
  assign imem_req_valid = (state_q == ST_REQ) && !trap;
  assign fd_valid       = (state_q == ST_HOLD);
  assign fd_pc          = pc;
  assign fd_instr       = instr_q;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    pc_load = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          pc_load = 1'b1;
          // A request accepted alongside a redirect still returns data; flag it stale.
          if (imem_req_valid && imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end else if (trap) begin
          state_d = ST_HOLD;
          instr_d = NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
          misalign_d = 1'b1;
`endif
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_load = 1'b1;
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d = imem_rsp_data;
            state_d = ST_HOLD;
`ifdef MISALIGN_TRAP_EN
            misalign_d = 1'b0;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (redirect || fd_ready) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      instr_q <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module : tb_pc_fetch_unit
// Brief  : Self-checking bench for pc_fetch_unit: table-driven fetches,
//          directed corner sequences and a randomized run against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_misalign;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .redirect       (redirect),
    .pc_plus4       (pc_plus4),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_pc          (fd_pc),
    .fd_instr       (fd_instr),
    .fd_misalign    (fd_misalign)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    int          delay;
    logic [31:0] nxt;
    logic [31:0] exp_pc;
    logic [31:0] exp_plus4;
    logic [31:0] exp_next_addr;
  } vec_t;

  vec_t tbl[4];

  // reference model: a fetch is either wanted, in flight (possibly stale) or held
  bit          m_boot, m_want, m_inflight, m_stale, m_have;
  logic [31:0] m_pc, m_instr;
  bit          mem_pend;
  int          mem_delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input bit rdy, input bit rspv, input logic [31:0] rspd,
                            input bit redir, input logic [31:0] np, input bit fdr);
    if (m_boot) begin
      m_boot = 0;
      m_want = 1;
    end else if (redir) begin
      m_pc = np;
      if (m_want) begin
        if (rdy) begin m_want = 0; m_inflight = 1; m_stale = 1; end
      end else if (m_inflight) begin
        if (rspv) begin m_inflight = 0; m_stale = 0; m_want = 1; end
        else m_stale = 1;
      end else if (m_have) begin
        m_have = 0;
        m_want = 1;
      end
    end else if (m_want && rdy) begin
      m_want = 0;
      m_inflight = 1;
    end else if (m_inflight && rspv) begin
      m_inflight = 0;
      if (m_stale) begin m_stale = 0; m_want = 1; end
      else begin m_have = 1; m_instr = rspd; end
    end else if (m_have && fdr) begin
      m_have = 0;
      m_pc = np;
      m_want = 1;
    end
  endtask

  initial begin
    bit          rdy, rspv, redir, fdr, accepted;
    logic [31:0] rspd, np;

    tbl[0] = '{32'h0050_0093, 1, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    tbl[1] = '{32'h00A0_0113, 3, 32'h0000_010C, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
    tbl[2] = '{32'h1234_5678, 2, 32'h0000_0400, 32'h0000_010C, 32'h0000_0110, 32'h0000_0400};
    tbl[3] = '{32'hCAFE_F00D, 1, 32'h0000_0104, 32'h0000_0400, 32'h0000_0404, 32'h0000_0104};

    rst = 1; next_pc = 0; redirect = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; fd_ready = 0;
    step(); step();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_fd_valid", {31'd0, fd_valid}, 32'd0);
    chk("rst_misalign", {31'd0, fd_misalign}, 32'd0);
    chk("rst_fd_instr", fd_instr, 32'd0);
    chk("rst_fd_pc", fd_pc, 32'h100);
    chk("rst_pc_plus4", pc_plus4, 32'h104);

    rst = 0;
    chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, 32'h100);

    for (int i = 0; i < 4; i++) begin
      chk("tbl_req_addr", imem_addr, tbl[i].exp_pc);
      imem_req_ready = 1;
      step();
      imem_req_ready = 0;
      chk("tbl_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("tbl_pc_plus4", pc_plus4, tbl[i].exp_plus4);
      for (int d = 1; d < tbl[i].delay; d++) step();
      imem_rsp_valid = 1; imem_rsp_data = tbl[i].data;
      step();
      imem_rsp_valid = 0;
      chk("tbl_fd_valid", {31'd0, fd_valid}, 32'd1);
      chk("tbl_fd_pc", fd_pc, tbl[i].exp_pc);
      chk("tbl_fd_instr", fd_instr, tbl[i].data);
      fd_ready = 1; next_pc = tbl[i].nxt;
      step();
      fd_ready = 0;
      chk("tbl_fd_valid_drop", {31'd0, fd_valid}, 32'd0);
      chk("tbl_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("tbl_next_addr", imem_addr, tbl[i].exp_next_addr);
    end

    // decode stall in HOLD
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111; step(); imem_rsp_valid = 0;
    next_pc = 32'h108;
    repeat (5) begin
      step();
      chk("stall_fd_valid", {31'd0, fd_valid}, 32'd1);
      chk("stall_fd_pc", fd_pc, 32'h104);
      chk("stall_fd_instr", fd_instr, 32'h1111_1111);
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    fd_ready = 1; step(); fd_ready = 0;
    chk("stall_release_addr", imem_addr, 32'h108);

    // redirect while waiting: late response must be discarded
    imem_req_ready = 1; step(); imem_req_ready = 0;
    redirect = 1; next_pc = 32'h200; step(); redirect = 0;
    chk("redir_wait_fd_valid", {31'd0, fd_valid}, 32'd0);
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; step(); imem_rsp_valid = 0;
    chk("redir_discard_fd_valid", {31'd0, fd_valid}, 32'd0);
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_req_addr", imem_addr, 32'h200);

    // redirect in REQ without accept, then wraparound PC and backpressure
    redirect = 1; next_pc = 32'hFFFF_FFFC; step(); redirect = 0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    repeat (4) begin
      step();
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_addr, 32'hFFFF_FFFC);
    end
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'hABCD_0001; step(); imem_rsp_valid = 0;
    chk("wrap_fd_pc", fd_pc, 32'hFFFF_FFFC);
    fd_ready = 1; next_pc = 32'h202; step(); fd_ready = 0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    chk("mis_fd_valid", {31'd0, fd_valid}, 32'd1);
    chk("mis_fd_instr", fd_instr, 32'h0000_0013);
    chk("mis_flag", {31'd0, fd_misalign}, 32'd1);
`else
    chk("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mis_addr", imem_addr, 32'h200);
    chk("mis_flag", {31'd0, fd_misalign}, 32'd0);
    chk("mis_fd_pc", fd_pc, 32'h202);
`endif

    // randomized run; reset mid-operation first
    rst = 1; step(); rst = 0;
    imem_rsp_valid = 0; imem_req_ready = 0; redirect = 0; fd_ready = 0;
    m_boot = 1; m_want = 0; m_inflight = 0; m_stale = 0; m_have = 0;
    m_pc = 32'h100; m_instr = 32'h0;
    mem_pend = 0; mem_delay = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 2) != 0);
      rspv  = mem_pend && (mem_delay == 0);
      rspd  = $urandom;
      redir = ($urandom_range(0, 9) == 0);
      fdr   = ($urandom_range(0, 2) != 0);
      np    = $urandom;
`ifdef MISALIGN_TRAP_EN
      np[1:0] = 2'b00;
`endif
      accepted = imem_req_valid && rdy;
      imem_req_ready = rdy; imem_rsp_valid = rspv; imem_rsp_data = rspd;
      redirect = redir; fd_ready = fdr; next_pc = np;
      step();
      model_edge(rdy, rspv, rspd, redir, np, fdr);
      if (rspv) mem_pend = 0;
      else if (mem_pend && mem_delay > 0) mem_delay--;
      if (accepted) begin mem_pend = 1; mem_delay = $urandom_range(0, 2); end
      chk("rnd_req_valid", {31'd0, imem_req_valid}, {31'd0, m_want});
      chk("rnd_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
      chk("rnd_fd_valid", {31'd0, fd_valid}, {31'd0, m_have});
      chk("rnd_fd_pc", fd_pc, m_pc);
      chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("rnd_misalign", {31'd0, fd_misalign}, 32'd0);
      if (m_have) chk("rnd_fd_instr", fd_instr, m_instr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
